// File: rtl/vme_cmd_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : vme_cmd_pkg                                                |
// | Shared state encoding, command/response bit positions and the error  |
// | data word for the VME command responder.                             |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package vme_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_DECODE  = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RESPOND = 3'd4
  } state_t;

  // Command word layout
  localparam int READ_BIT  = 25;
  localparam int WRITE_BIT = 24;
  localparam int TAG_HI    = 23;
  localparam int TAG_LO    = 16;
  localparam int DEV_HI    = 15;
  localparam int DEV_LO    = 12;
  localparam int ADDR_HI   = 11;
  localparam int ADDR_LO   = 0;

  // Response word layout
  localparam int DATA_HI      = 15;
  localparam int DATA_LO      = 0;
  localparam int FLAG_TIMEOUT = 16;
  localparam int FLAG_BAD_TAG = 17;
  localparam int FLAG_BAD_CMD = 18;
  localparam int FLAG_READ    = 19;

  localparam logic [15:0] ERR_DATA = 16'hDEAD;

endpackage : vme_cmd_pkg
`default_nettype wire

// File: rtl/vme_cmd_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : vme_cmd_timer                                              |
// | Wait-cycle counter; tc is high while the count sits at LIMIT-1, i.e. |
// | the current enabled cycle is the LIMIT-th one.                       |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module vme_cmd_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count;

  // Count enabled cycles, restarting from zero on clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == CNT_W'(LIMIT - 1));

endmodule : vme_cmd_timer
`default_nettype wire

// File: rtl/vme_cmd_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : vme_cmd_responder                                          |
// | Target-side VME command endpoint: latches one command, performs one  |
// | device-bus access and returns a response word with a 1-cycle strobe. |
// | Option  : define VME_CMD_TIMEOUT_EN to add the WAIT timeout.         |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module vme_cmd_responder
  import vme_cmd_pkg::*;
#(
  parameter logic [7:0]  BOARD_TAG      = 8'hA8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] vme_cmd_reg,
  input  logic [31:0] vme_dat_reg_in,
  output logic [31:0] vme_dat_reg_out,
  output logic        vme_cmd_rd,
  output logic        vme_dat_wr,
  output logic [15:0] dev_sel,
  output logic [11:0] dev_addr,
  output logic [15:0] dev_wdata,
  output logic        dev_we,
  output logic        dev_strobe,
  input  logic [15:0] dev_rdata,
  input  logic        dev_ack
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("vme_cmd_responder: TIMEOUT_CYCLES must be 1..65535");
  end

  state_t      state, state_nxt;
  logic [25:0] cmd_q;
  logic [15:0] wdata_q;
  logic [31:0] resp_q, resp_nxt;
  logic        load_resp;
  logic        timeout_hit;
  logic        dev_active;

  // Upper command bits and upper write-data bits carry nothing for us
  logic unused_bits;
  assign unused_bits = ^{vme_cmd_reg[31:26], vme_dat_reg_in[31:16]};

`ifdef VME_CMD_TIMEOUT_EN
  logic tmo_clear, tmo_enable, tmo_tc;
  assign tmo_clear  = (state == ST_ACCESS);
  assign tmo_enable = (state == ST_WAIT) && !dev_ack;

  vme_cmd_timer #(.LIMIT(TIMEOUT_CYCLES)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (tmo_clear),
    .enable (tmo_enable),
    .tc     (tmo_tc)
  );

  // Ack takes precedence because the FSM tests dev_ack before timeout_hit
  assign timeout_hit = (state == ST_WAIT) && tmo_tc;
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Capture the command only when the responder is ready for one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q   <= '0;
      wdata_q <= '0;
    end else if (state == ST_IDLE && start) begin
      cmd_q   <= vme_cmd_reg[25:0];
      wdata_q <= vme_dat_reg_in[15:0];
    end
  end

  // Response word is loaded on entry to RESPOND and held afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         resp_q <= '0;
    else if (load_resp) resp_q <= resp_nxt;
  end

  // Next-state decode and response assembly
  always_comb begin
    state_nxt = state;
    load_resp = 1'b0;
    resp_nxt  = '0;
    resp_nxt[FLAG_READ] = cmd_q[READ_BIT];
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_DECODE;
      end
      ST_DECODE: begin
        if (cmd_q[TAG_HI:TAG_LO] != BOARD_TAG) begin
          resp_nxt[DATA_HI:DATA_LO] = ERR_DATA;
          resp_nxt[FLAG_BAD_TAG]    = 1'b1;
          load_resp = 1'b1;
          state_nxt = ST_RESPOND;
        end else if (!cmd_q[READ_BIT] && !cmd_q[WRITE_BIT]) begin
          resp_nxt[DATA_HI:DATA_LO] = ERR_DATA;
          resp_nxt[FLAG_BAD_CMD]    = 1'b1;
          load_resp = 1'b1;
          state_nxt = ST_RESPOND;
        end else begin
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS, ST_WAIT: begin
        if (dev_ack) begin
          resp_nxt[DATA_HI:DATA_LO] = cmd_q[READ_BIT] ? dev_rdata : 16'h0000;
          load_resp = 1'b1;
          state_nxt = ST_RESPOND;
        end else if (timeout_hit) begin
          resp_nxt[DATA_HI:DATA_LO] = ERR_DATA;
          resp_nxt[FLAG_TIMEOUT]    = 1'b1;
          load_resp = 1'b1;
          state_nxt = ST_RESPOND;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      ST_RESPOND: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Device fields are only driven while an access is in flight
  assign dev_active = (state == ST_ACCESS) || (state == ST_WAIT);
  assign dev_sel    = dev_active ? (16'h0001 << cmd_q[DEV_HI:DEV_LO]) : 16'h0000;
  assign dev_addr   = dev_active ? cmd_q[ADDR_HI:ADDR_LO] : 12'h000;
  assign dev_wdata  = dev_active ? wdata_q : 16'h0000;
  assign dev_we     = dev_active && !cmd_q[READ_BIT];
  assign dev_strobe = (state == ST_ACCESS);

  assign vme_cmd_rd      = (state == ST_IDLE);
  assign vme_dat_wr      = (state == ST_RESPOND);
  assign vme_dat_reg_out = resp_q;

endmodule : vme_cmd_responder
`default_nettype wire

// File: tb/tb_vme_cmd_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_vme_cmd_responder                                       |
// | Scoreboard bench: directed commands push expected responses and      |
// | device accesses; a monitor pops and compares on each strobe.         |
// | Option  : VME_CMD_TIMEOUT_EN enables the timeout vector.             |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_vme_cmd_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] vme_cmd_reg = '0;
  logic [31:0] vme_dat_reg_in = '0;
  logic [31:0] vme_dat_reg_out;
  logic        vme_cmd_rd, vme_dat_wr;
  logic [15:0] dev_sel, dev_wdata;
  logic [11:0] dev_addr;
  logic        dev_we, dev_strobe;
  logic [15:0] dev_rdata = '0;
  logic        dev_ack = 1'b0;

  vme_cmd_responder #(.BOARD_TAG(8'hA8), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .vme_cmd_reg(vme_cmd_reg), .vme_dat_reg_in(vme_dat_reg_in),
    .vme_dat_reg_out(vme_dat_reg_out), .vme_cmd_rd(vme_cmd_rd),
    .vme_dat_wr(vme_dat_wr), .dev_sel(dev_sel), .dev_addr(dev_addr),
    .dev_wdata(dev_wdata), .dev_we(dev_we), .dev_strobe(dev_strobe),
    .dev_rdata(dev_rdata), .dev_ack(dev_ack)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic [31:0] out;
    int          cyc;
  } resp_t;

  typedef struct {
    string       name;
    logic [44:0] fields;  // {sel, addr, we, wdata}
  } dev_t;

  resp_t resp_q[$];
  dev_t  dev_q[$];
  int    tests = 0;
  int    fails = 0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: every response strobe and device strobe is matched to the scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (vme_dat_wr) begin
        if (resp_q.size() == 0) begin
          check("unexpected_vme_dat_wr", 64'd1, 64'd0);
        end else begin
          resp_t e;
          e = resp_q.pop_front();
          check({e.name, "_out"}, 64'(vme_dat_reg_out), 64'(e.out));
          check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
        end
      end
      if (dev_strobe) begin
        if (dev_q.size() == 0) begin
          check("unexpected_dev_strobe", 64'd1, 64'd0);
        end else begin
          dev_t d;
          d = dev_q.pop_front();
          check({d.name, "_dev_fields"}, 64'({dev_sel, dev_addr, dev_we, dev_wdata}), 64'(d.fields));
        end
      end
    end
  end

  // Issue one command; ack_k < 0 means the device never acks
  task automatic run_cmd(input string name, input logic [31:0] cmd, input logic [31:0] din,
                         input int ack_k, input logic [15:0] rdata,
                         input logic [31:0] exp_out, input int exp_lat,
                         input bit exp_dev, input logic [44:0] exp_fields);
    int  n;
    bit  done;
    resp_t r;
    dev_t  d;
    @(negedge clk);
    n = cyc;
    vme_cmd_reg    = cmd;
    vme_dat_reg_in = din;
    dev_rdata      = rdata;
    start          = 1'b1;
    r.name = name; r.out = exp_out; r.cyc = n + exp_lat;
    resp_q.push_back(r);
    if (exp_dev) begin
      d.name = name; d.fields = exp_fields;
      dev_q.push_back(d);
    end
    done = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      start   = 1'b0;
      dev_ack = (ack_k >= 0) && (cyc == n + 2 + ack_k);
      if (cyc > n + 1 && vme_cmd_rd) begin
        done = 1'b1;
        break;
      end
    end
    dev_ack = 1'b0;
    if (!done) check({name, "_completion_timeout"}, 64'd0, 64'd1);
    check({name, "_out_held"}, 64'(vme_dat_reg_out), 64'(exp_out));
    check({name, "_idle_dev"}, 64'({dev_sel, dev_addr, dev_we, dev_strobe}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({vme_dat_reg_out, vme_cmd_rd, vme_dat_wr, dev_strobe, dev_we}),
          64'({32'h0, 1'b1, 1'b0, 1'b0, 1'b0}));
    check("reset_dev_fields", 64'({dev_sel, dev_addr, dev_wdata}), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write, ack in the third WAIT cycle; read data must not leak into a write response
    run_cmd("write", 32'h01A8_2004, 32'h0000_1234, 3, 16'hFFFF,
            32'h0000_0000, 6, 1'b1, {16'h0004, 12'h004, 1'b1, 16'h1234});
    // Read, ack in the ACCESS cycle
    run_cmd("read", 32'h02A8_3010, 32'h0000_0000, 0, 16'hBEEF,
            32'h0008_BEEF, 3, 1'b1, {16'h0008, 12'h010, 1'b0, 16'h0000});
    // Bad tag (read bit set so was-read also reports)
    run_cmd("bad_tag", 32'h0255_2004, 32'h0000_0000, 0, 16'h0000,
            32'h000A_DEAD, 2, 1'b0, 45'd0);
    // Neither read nor write
    run_cmd("bad_cmd", 32'h00A8_2004, 32'h0000_0000, 0, 16'h0000,
            32'h0004_DEAD, 2, 1'b0, 45'd0);
    // Both bits set: read wins; highest device and address
    run_cmd("rw_both", 32'h03A8_FFFF, 32'hFFFF_5A5A, 1, 16'hA5A5,
            32'h0008_A5A5, 4, 1'b1, {16'h8000, 12'hFFF, 1'b0, 16'h5A5A});
    // Ack on the eighth WAIT cycle (the timeout terminal cycle when enabled)
    run_cmd("ack_at_limit", 32'h02A8_0001, 32'h0000_0000, 8, 16'h0001,
            32'h0008_0001, 11, 1'b1, {16'h0001, 12'h001, 1'b0, 16'h0000});
`ifdef VME_CMD_TIMEOUT_EN
    run_cmd("timeout", 32'h02A8_4001, 32'h0000_0000, -1, 16'h0000,
            32'h0009_DEAD, 11, 1'b1, {16'h0010, 12'h001, 1'b0, 16'h0000});
`endif

    // Stray ack while idle must not produce a response
    @(negedge clk); dev_ack = 1'b1;
    @(negedge clk); dev_ack = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of WAIT
    begin
      dev_t d;
      @(negedge clk);
      vme_cmd_reg = 32'h02A8_5002; vme_dat_reg_in = '0; start = 1'b1;
      d.name = "rst_mid"; d.fields = {16'h0020, 12'h002, 1'b0, 16'h0000};
      dev_q.push_back(d);
      @(negedge clk); start = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mid_pre_sel", 64'(dev_sel), 64'h0020);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_outputs",
            64'({vme_cmd_rd, vme_dat_wr, dev_strobe, dev_we, dev_sel, dev_addr}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 12'h0}));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
    end

    run_cmd("after_rst", 32'h01A8_7123, 32'hABCD_9876, 1, 16'h0000,
            32'h0000_0000, 4, 1'b1, {16'h0080, 12'h123, 1'b1, 16'h9876});

    repeat (4) @(negedge clk);
    check("resp_queue_drained", 64'(resp_q.size()), 64'd0);
    check("dev_queue_drained", 64'(dev_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_vme_cmd_responder
`default_nettype wire

// File: doc/vme_cmd_responder.md
# vme_cmd_responder

Synthesizable target-side endpoint of the simulation VME command channel. It accepts one command at a time on the `start`/`vme_cmd_reg`/`vme_dat_reg_in` interface and signals readiness on `vme_cmd_rd`. It decodes each command into a single access on the internal device bus and returns read data or write status with a one-cycle `vme_dat_wr` strobe. It sits between the VME front end (or the testbench command player) and the ODMB register devices.

## Interface
- `BOARD_TAG`, default 8'hA8: required value of `vme_cmd_reg[23:16]`.
- `TIMEOUT_CYCLES`, default 255: maximum WAIT cycles before forced timeout response; legal range 1..65535.
- `clk` in 1: single clock for all logic.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `start` in 1: command valid; sampled only in IDLE.
- `vme_cmd_reg` in 32: [25] read, [24] write, [23:16] board tag, [15:12] device, [11:0] register address.
- `vme_dat_reg_in` in 32: write data in [15:0]; [31:16] ignored.
- `vme_dat_reg_out` out 32: response word: [15:0] data, [16] timeout, [17] bad tag, [18] bad command, [19] was-read, [31:20] zero.
- `vme_cmd_rd` out 1: high in IDLE only; the responder can accept a command.
- `vme_dat_wr` out 1: one-cycle strobe marking `vme_dat_reg_out` valid.
- `dev_sel` out 16: one-hot decode of `vme_cmd_reg[15:12]`.
- `dev_addr` out 12, `dev_wdata` out 16, `dev_we` out 1: device access fields.
- `dev_strobe` out 1: one-cycle access request.
- `dev_rdata` in 16, `dev_ack` in 1: device completion and read data.

## Operation
- States: IDLE, DECODE, ACCESS, WAIT, RESPOND.
- **IDLE**
  - `vme_cmd_rd`=1.
  - When `start`=1, latch `vme_cmd_reg` and `vme_dat_reg_in` and go to DECODE.
  - `start` in any other state is ignored.
- **DECODE**
  - If tag ≠ `BOARD_TAG`: set bad-tag, go to RESPOND.
  - If [25]=0 and [24]=0: set bad-cmd, go to RESPOND.
  - If [25]=1, the command is a read; bit [25] takes priority over [24].
  - Otherwise go to ACCESS.
- **ACCESS**
  - Drive `dev_sel`, `dev_addr`, `dev_we`, `dev_wdata` from the latched command.
  - Hold these fields stable until leaving WAIT.
  - Pulse `dev_strobe` for exactly one cycle.
  - `dev_ack` is sampled from ACCESS onward.
- **WAIT**
  - Hold the device fields and wait for `dev_ack`.
  - On ack: capture `dev_rdata` for a read, or zero for a write, and go to RESPOND.
- **RESPOND**
  - `vme_dat_wr`=1 for one cycle, with `vme_dat_reg_out` updated in the same cycle.
  - `vme_dat_reg_out` holds its value until the next RESPOND.
  - Next state is IDLE.
- Error and timeout responses return data 16'hDEAD with the matching flag set.
- `dev_sel`=0 and `dev_we`=0 outside ACCESS/WAIT.

## Timing
- Reset values: all outputs 0 except `vme_cmd_rd`=1 (state IDLE).
- `vme_dat_reg_out`=0 after reset.
- Cycle N `start` sampled → N+1 DECODE → N+2 ACCESS (`dev_strobe`).
- Ack in cycle N+2+k (k≥0) → `vme_dat_wr` at N+3+k → `vme_cmd_rd` high at N+4+k.
- Bad tag or bad command: `vme_dat_wr` at N+2, no device strobe.
- Timeout: counter clears on entry to ACCESS and increments each cycle without ack. On reaching `TIMEOUT_CYCLES`, go to RESPOND with the timeout flag.
- Ack in the same cycle the counter reaches the limit: the ack wins; no timeout.
- `dev_ack` outside ACCESS/WAIT is ignored.
- Reset mid-operation: immediate return to IDLE, strobe dropped, no `vme_dat_wr`.

## Configuration
- `VME_CMD_TIMEOUT_EN` defined: timeout counter and timeout flag present, as above.
- Undefined: WAIT exits only on `dev_ack`; bit [16] is tied 0; `TIMEOUT_CYCLES` is unused.

## Structure
- Package `vme_cmd_pkg` holds:
  - state enum;
  - bit-position constants (READ_BIT=25, WRITE_BIT=24, TAG_HI/LO=23/16, flag bits 16..19);
  - `ERR_DATA`=16'hDEAD.
- One sub-module: `vme_cmd_timer`, with clear, enable, terminal-count output, and width derived from `TIMEOUT_CYCLES`. It is instantiated only under `VME_CMD_TIMEOUT_EN`.

## Test plan
- Write: `start` with cmd 32'h01A8_2004, data 32'h0000_1234, ack after 3 cycles.
  - Expect `dev_sel`=16'h0004, `dev_addr`=12'h004, `dev_we`=1, `dev_wdata`=16'h1234, one `dev_strobe`.
  - Expect `vme_dat_wr` with `vme_dat_reg_out`=32'h0.
- Read: cmd 32'h02A8_3010, `dev_rdata`=16'hBEEF, ack in the ACCESS cycle.
  - Expect `vme_dat_wr` 3 cycles after `start` with out=32'h0008_BEEF.
- Bad tag: cmd 32'h0255_2004.
  - Expect no `dev_strobe`; `vme_dat_wr` at N+2 with out=32'h000A_DEAD.
- Bad command: cmd 32'h00A8_2004 (neither R nor W).
  - Expect out=32'h0004_DEAD, no strobe.
- Timeout (macro on, `TIMEOUT_CYCLES`=8): read with no ack.
  - Expect out=32'h0009_DEAD after 8 WAIT cycles.
  - Ack on the terminal cycle instead gives normal data.
- Reset mid-WAIT: assert `rst_n`=0.
  - Expect `vme_cmd_rd`=1 and all device outputs 0 immediately, with no `vme_dat_wr`.
  - A subsequent `start` is serviced normally.
